// File: rtl/hdr_patch_ctrl_if.sv
// Bus bundle between the header patch sequencer and its environment:
// descriptor queue, the UDP and IP patchers, and the header-buffer write port.
interface hdr_patch_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int HDR_AW     = 6
);
  logic                  i_pkt_valid;
  logic                  o_pkt_ready;
  logic [ADDR_WIDTH-1:0] i_data_st;
  logic [ADDR_WIDTH-1:0] i_next_data_st;
  logic                  o_udp_trig;
  logic [ADDR_WIDTH-1:0] o_data_st;
  logic [ADDR_WIDTH-1:0] o_next_data_st;
  logic [2:0]            i_udp_idx;
  logic [7:0]            i_udp_byte;
  logic                  i_udp_wr_en;
  logic                  i_udp_ready;
  logic                  o_ip_trig;
  logic [15:0]           o_ip_len;
  logic [HDR_AW-1:0]     i_ip_idx;
  logic [7:0]            i_ip_byte;
  logic                  i_ip_wr_en;
  logic                  i_ip_ready;
  logic [HDR_AW-1:0]     o_hdr_addr;
  logic [7:0]            o_hdr_data;
  logic                  o_hdr_wr_en;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;

  // controller side
  modport master (
    input  i_pkt_valid, i_data_st, i_next_data_st,
    input  i_udp_idx, i_udp_byte, i_udp_wr_en, i_udp_ready,
    input  i_ip_idx, i_ip_byte, i_ip_wr_en, i_ip_ready,
    output o_pkt_ready, o_udp_trig, o_data_st, o_next_data_st,
    output o_ip_trig, o_ip_len, o_hdr_addr, o_hdr_data, o_hdr_wr_en,
    output o_busy, o_done, o_err
  );

  // environment side (descriptor queue, patchers, header buffer)
  modport slave (
    output i_pkt_valid, i_data_st, i_next_data_st,
    output i_udp_idx, i_udp_byte, i_udp_wr_en, i_udp_ready,
    output i_ip_idx, i_ip_byte, i_ip_wr_en, i_ip_ready,
    input  o_pkt_ready, o_udp_trig, o_data_st, o_next_data_st,
    input  o_ip_trig, o_ip_len, o_hdr_addr, o_hdr_data, o_hdr_wr_en,
    input  o_busy, o_done, o_err
  );
endinterface

// File: rtl/hdr_patch_ctrl.sv
// Header patch sequencer: runs the UDP length patcher then the IP
// length/checksum patcher for one packet, muxing their byte writes onto the
// header buffer and aborting a stage that does not report ready in time.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for a descriptor, o_pkt_ready high
// UDP_TRIG   | o_udp_trig high for two cycles
// UDP_WAIT   | waiting for i_udp_ready, timeout timer running
// IP_TRIG    | o_ip_trig high for two cycles
// IP_WAIT    | waiting for i_ip_ready, timeout timer running
// DONE       | one-cycle o_done pulse
// ERR        | one-cycle o_err pulse after a stage timeout
module hdr_patch_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int HDR_AW     = 6,
  parameter int UDP_BASE   = 20,
  parameter int TIMEOUT    = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  hdr_patch_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_UDP_TRIG, S_UDP_WAIT, S_IP_TRIG, S_IP_WAIT, S_DONE, S_ERR
  } state_t;

  // The timer is a down-counter: loaded on entry to a TRIG or WAIT state and
  // the state ends at terminal count zero. TIMEOUT-1 load gives TIMEOUT wait
  // cycles, 1 gives the two-cycle trigger pulse.
  localparam logic [7:0] TMR_WAIT = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMR_TRIG = 8'd1;

  state_t                state, state_nxt;
  logic [7:0]            tmr, tmr_nxt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] span;
  logic [HDR_AW-1:0]     udp_addr;

  assign span     = bus.i_next_data_st - bus.i_data_st;
  assign udp_addr = HDR_AW'(UDP_BASE) + HDR_AW'(bus.i_udp_idx);

  // State and timer registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state and timer logic; ready wins over a coincident terminal count
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_pkt_valid) begin
          accept    = 1'b1;
          state_nxt = S_UDP_TRIG;
          tmr_nxt   = TMR_TRIG;
        end
      end
      S_UDP_TRIG: begin
        if (tmr == 8'd0) begin
          state_nxt = S_UDP_WAIT;
          tmr_nxt   = TMR_WAIT;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      S_UDP_WAIT: begin
        if (bus.i_udp_ready) begin
          state_nxt = S_IP_TRIG;
          tmr_nxt   = TMR_TRIG;
        end else if (tmr == 8'd0) begin
          state_nxt = S_ERR;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      S_IP_TRIG: begin
        if (tmr == 8'd0) begin
          state_nxt = S_IP_WAIT;
          tmr_nxt   = TMR_WAIT;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      S_IP_WAIT: begin
        if (bus.i_ip_ready) begin
          state_nxt = S_DONE;
        end else if (tmr == 8'd0) begin
          state_nxt = S_ERR;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // Status and triggers decode straight from the state register
  assign bus.o_pkt_ready = (state == S_IDLE);
  assign bus.o_busy      = (state != S_IDLE);
  assign bus.o_udp_trig  = (state == S_UDP_TRIG);
  assign bus.o_ip_trig   = (state == S_IP_TRIG);
  assign bus.o_done      = (state == S_DONE);
  assign bus.o_err       = (state == S_ERR);

  // Descriptor capture; pointers stay frozen for the patchers until next accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_data_st      <= '0;
      bus.o_next_data_st <= '0;
      bus.o_ip_len       <= '0;
    end else if (accept) begin
      bus.o_data_st      <= bus.i_data_st;
      bus.o_next_data_st <= bus.i_next_data_st;
      bus.o_ip_len       <= 16'(span) + 16'd30;
    end
  end

  // Header write mux: only the patcher owning the current stage reaches the buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_hdr_addr  <= '0;
      bus.o_hdr_data  <= '0;
      bus.o_hdr_wr_en <= 1'b0;
    end else begin
      case (state)
        S_UDP_TRIG, S_UDP_WAIT: begin
          bus.o_hdr_addr  <= udp_addr;
          bus.o_hdr_data  <= bus.i_udp_byte;
          bus.o_hdr_wr_en <= bus.i_udp_wr_en;
        end
        S_IP_TRIG, S_IP_WAIT: begin
          bus.o_hdr_addr  <= bus.i_ip_idx;
          bus.o_hdr_data  <= bus.i_ip_byte;
          bus.o_hdr_wr_en <= bus.i_ip_wr_en;
        end
        default: begin
          bus.o_hdr_wr_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hdr_patch_ctrl.sv
// Bench for hdr_patch_ctrl: each packet is described by when the patchers
// answer; the expected output timeline is derived from that with plain
// arithmetic and compared cycle by cycle, with random patcher write traffic.
module tb_hdr_patch_ctrl;
  localparam int ADDR_WIDTH = 11;
  localparam int HDR_AW     = 6;
  localparam int UDP_BASE   = 20;
  localparam int TIMEOUT    = 64;

  localparam int P_IDLE = 0, P_UT = 1, P_UW = 2, P_IT = 3, P_IW = 4, P_DONE = 5, P_ERR = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic              exp_wr = 1'b0;
  logic [HDR_AW-1:0] exp_addr = '0;
  logic [7:0]        exp_data = '0;

  hdr_patch_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH), .HDR_AW(HDR_AW)) bus ();

  hdr_patch_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .HDR_AW(HDR_AW), .UDP_BASE(UDP_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Phase of cycle c of a packet (c=0 is the accepting IDLE cycle), given the
  // wait-cycle offset at which each patcher answers (-1 = never answers).
  function automatic int phase(int c, int u, int v);
    int iw0;
    if (c == 0) return P_IDLE;
    if (c <= 2) return P_UT;
    if (u < 0) return (c < 3 + TIMEOUT) ? P_UW : ((c == 3 + TIMEOUT) ? P_ERR : P_IDLE);
    if (c <= 3 + u) return P_UW;
    if (c <= 5 + u) return P_IT;
    iw0 = 6 + u;
    if (v < 0) return (c < iw0 + TIMEOUT) ? P_IW : ((c == iw0 + TIMEOUT) ? P_ERR : P_IDLE);
    if (c <= iw0 + v) return P_IW;
    return (c == iw0 + v + 1) ? P_DONE : P_IDLE;
  endfunction

  task automatic check_reset();
    chk("rst_pkt_ready", 32'(bus.o_pkt_ready), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_udp_trig", 32'(bus.o_udp_trig), 32'd0);
    chk("rst_ip_trig", 32'(bus.o_ip_trig), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_hdr_wr_en", 32'(bus.o_hdr_wr_en), 32'd0);
    chk("rst_hdr_addr", 32'(bus.o_hdr_addr), 32'd0);
    chk("rst_hdr_data", 32'(bus.o_hdr_data), 32'd0);
    chk("rst_ip_len", 32'(bus.o_ip_len), 32'd0);
    chk("rst_data_st", 32'(bus.o_data_st), 32'd0);
    chk("rst_next_data_st", 32'(bus.o_next_data_st), 32'd0);
  endtask

  task automatic check_cycle(input int ph, input bit live, input logic [10:0] st,
                             input logic [10:0] nx, input logic [15:0] len);
    chk("pkt_ready", 32'(bus.o_pkt_ready), 32'(ph == P_IDLE));
    chk("busy", 32'(bus.o_busy), 32'(ph != P_IDLE));
    chk("udp_trig", 32'(bus.o_udp_trig), 32'(ph == P_UT));
    chk("ip_trig", 32'(bus.o_ip_trig), 32'(ph == P_IT));
    chk("done", 32'(bus.o_done), 32'(ph == P_DONE));
    chk("err", 32'(bus.o_err), 32'(ph == P_ERR));
    chk("hdr_wr_en", 32'(bus.o_hdr_wr_en), 32'(exp_wr));
    chk("hdr_addr", 32'(bus.o_hdr_addr), 32'(exp_addr));
    chk("hdr_data", 32'(bus.o_hdr_data), 32'(exp_data));
    if (live) begin
      chk("ip_len", 32'(bus.o_ip_len), 32'(len));
      chk("data_st", 32'(bus.o_data_st), 32'(st));
      chk("next_data_st", 32'(bus.o_next_data_st), 32'(nx));
    end
  endtask

  // Drive one cycle of stimulus and advance the expected header-write state.
  task automatic drive(input int c, input int ph, input int u, input int v,
                       input logic [10:0] st, input logic [10:0] nx, input bit directed);
    bit udp_stage, ip_stage;
    udp_stage = (ph == P_UT) || (ph == P_UW);
    ip_stage  = (ph == P_IT) || (ph == P_IW);
    bus.i_pkt_valid    = 1'b1;
    bus.i_data_st      = (c == 0) ? st : 11'($urandom);
    bus.i_next_data_st = (c == 0) ? nx : 11'($urandom);
    bus.i_udp_ready    = (u >= 0 && c == 3 + u) ||
                         (!udp_stage && $urandom_range(0, 3) == 0);
    bus.i_ip_ready     = (u >= 0 && v >= 0 && c == 6 + u + v) ||
                         (!ip_stage && $urandom_range(0, 3) == 0);
    if (directed) begin
      bus.i_udp_wr_en = (c == 3) || (c == 4);
      bus.i_udp_idx   = (c == 3) ? 3'd4 : 3'd5;
      bus.i_udp_byte  = (c == 3) ? 8'h00 : 8'h4A;
      bus.i_ip_wr_en  = 1'b0;
      bus.i_ip_idx    = 6'($urandom);
      bus.i_ip_byte   = 8'($urandom);
    end else begin
      bus.i_udp_wr_en = 1'($urandom);
      bus.i_udp_idx   = 3'($urandom);
      bus.i_udp_byte  = 8'($urandom);
      bus.i_ip_wr_en  = 1'($urandom);
      bus.i_ip_idx    = 6'($urandom);
      bus.i_ip_byte   = 8'($urandom);
    end
    if (udp_stage) begin
      exp_wr   = bus.i_udp_wr_en;
      exp_addr = HDR_AW'(UDP_BASE + int'(bus.i_udp_idx));
      exp_data = bus.i_udp_byte;
    end else if (ip_stage) begin
      exp_wr   = bus.i_ip_wr_en;
      exp_addr = bus.i_ip_idx;
      exp_data = bus.i_ip_byte;
    end else begin
      exp_wr = 1'b0;
    end
  endtask

  task automatic quiet_inputs();
    bus.i_pkt_valid = 1'b0;
    bus.i_udp_ready = 1'b0;
    bus.i_ip_ready  = 1'b0;
    bus.i_udp_wr_en = 1'b0;
    bus.i_ip_wr_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_pkt_ready", 32'(bus.o_pkt_ready), 32'd1);
      chk("idle_hdr_wr_en", 32'(bus.o_hdr_wr_en), 32'(exp_wr));
      quiet_inputs();
      exp_wr = 1'b0;
    end
  endtask

  // One packet; u/v = wait-cycle offset of UDP/IP ready (-1 = none).
  task automatic run_pkt(input logic [10:0] st, input logic [10:0] nx, input int u,
                         input int v, input bit abort, input bit directed);
    logic [10:0] span;
    logic [15:0] len;
    int  c;
    bit  fin;
    span = nx - st;
    len  = 16'(span) + 16'd30;
    c    = 0;
    fin  = 1'b0;
    while (!fin) begin
      int ph;
      @(negedge clk);
      ph = phase(c, u, v);
      check_cycle(ph, c > 0, st, nx, len);
      if (ph == P_DONE || ph == P_ERR) fin = 1'b1;
      if (abort && ph == P_IW && c == 8 + u) begin
        rst = 1'b1;
        quiet_inputs();
        @(negedge clk);
        check_reset();
        rst      = 1'b0;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        return;
      end
      drive(c, ph, u, v, st, nx, directed);
      c++;
    end
  endtask

  initial begin
    bus.i_data_st      = '0;
    bus.i_next_data_st = '0;
    bus.i_udp_idx      = '0;
    bus.i_udp_byte     = '0;
    bus.i_ip_idx       = '0;
    bus.i_ip_byte      = '0;
    quiet_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    idle(2);

    // basic packet with UDP length writes at idx 4/5
    run_pkt(11'd100, 11'd164, 2, 5, 1'b0, 1'b1);
    idle(1);
    // pointer wrap: 8 - 2040 mod 2^11 = 16
    run_pkt(11'd2040, 11'd8, int'($urandom_range(0, 10)), int'($urandom_range(0, 10)), 1'b0, 1'b0);
    // UDP stage timeout
    run_pkt(11'($urandom), 11'($urandom), -1, 0, 1'b0, 1'b0);
    idle(1);
    // IP stage timeout
    run_pkt(11'($urandom), 11'($urandom), 3, -1, 1'b0, 1'b0);
    // ready on the final timeout cycle of both stages still succeeds
    run_pkt(11'($urandom), 11'($urandom), TIMEOUT - 1, TIMEOUT - 1, 1'b0, 1'b0);
    // ready immediately on WAIT entry
    run_pkt(11'($urandom), 11'($urandom), 0, 0, 1'b0, 1'b0);
    // reset during IP_WAIT, then a clean packet
    run_pkt(11'($urandom), 11'($urandom), 4, -1, 1'b1, 1'b0);
    run_pkt(11'($urandom), 11'($urandom), 1, 2, 1'b0, 1'b0);
    // valid held high: back-to-back random packets
    for (int k = 0; k < 10; k++) begin
      run_pkt(11'($urandom), 11'($urandom), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)), 1'b0, 1'b0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hdr_patch_ctrl.md
Name: hdr_patch_ctrl

Overview:
Sequences the two header patchers for one outgoing packet: first the UDP length patcher, then the IP length/checksum patcher. It accepts a packet descriptor, drives each patcher's trigger, and waits for each patcher's ready. It multiplexes both patchers' byte-write ports onto the single header-buffer write port, with a per-stage timeout. It sits between the TX packet descriptor queue and the header buffer.

Parameters:
ADDR_WIDTH, 11, width of data-buffer start pointers
HDR_AW, 6, header-buffer address width
UDP_BASE, 20, header-buffer byte offset of UDP header (UDP index 0 maps here)
TIMEOUT, 64, max cycles to wait for a patcher ready (range 2..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_pkt_valid  in  1  descriptor valid
o_pkt_ready  out  1  descriptor accept (high only in IDLE)
i_data_st  in  ADDR_WIDTH  payload start pointer
i_next_data_st  in  ADDR_WIDTH  next packet start pointer
o_udp_trig  out  1  UDP patcher trigger (patcher is rising-edge sensitive)
o_data_st  out  ADDR_WIDTH  latched i_data_st, held stable to patchers
o_next_data_st  out  ADDR_WIDTH  latched i_next_data_st
i_udp_idx  in  3  UDP patcher byte index
i_udp_byte  in  8  UDP patcher byte
i_udp_wr_en  in  1  UDP patcher write enable
i_udp_ready  in  1  UDP patcher done pulse
o_ip_trig  out  1  IP patcher trigger
o_ip_len  out  16  IP total length for IP patcher
i_ip_idx  in  HDR_AW  IP patcher byte address
i_ip_byte  in  8  IP patcher byte
i_ip_wr_en  in  1  IP patcher write enable
i_ip_ready  in  1  IP patcher done pulse
o_hdr_addr  out  HDR_AW  header-buffer write address
o_hdr_data  out  8  header-buffer write data
o_hdr_wr_en  out  1  header-buffer write enable
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse when both stages complete
o_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (sync, i_rst=1 at edge): state=IDLE; all outputs 0 except o_pkt_ready=1. Timer, latched pointers and o_ip_len are cleared. A reset mid-operation abandons the packet with no done/err pulse.
- States:
  - IDLE: o_pkt_ready=1. On i_pkt_valid: latch pointers; o_ip_len <= zero-extend(i_next_data_st - i_data_st, modulo 2^ADDR_WIDTH) + 30 (mod 2^16); go to UDP_TRIG.
  - UDP_TRIG: o_udp_trig=1 for exactly 2 cycles, then 0; go to UDP_WAIT. The trigger is low for at least 1 cycle before assertion, which IDLE guarantees.
  - UDP_WAIT: o_udp_trig=0; timer counts from 0. On i_udp_ready go to IP_TRIG. If the timer reaches TIMEOUT-1 without ready, go to ERR.
  - IP_TRIG / IP_WAIT: same as the UDP stages using o_ip_trig / i_ip_ready. On ready go to DONE.
  - DONE: o_done=1 for one cycle; go to IDLE.
  - ERR: o_err=1 for one cycle; go to IDLE.
- Descriptor handshake: accepted in the cycle where i_pkt_valid & o_pkt_ready. o_pkt_ready is registered and drops the cycle after accept. Back-to-back packets have at least 1 IDLE cycle between them.
- o_data_st and o_next_data_st are held constant from accept until the next accept.
- Write mux, registered with 1-cycle latency:
  - In UDP_TRIG/UDP_WAIT: o_hdr_addr = UDP_BASE + i_udp_idx (mod 2^HDR_AW), o_hdr_data = i_udp_byte, o_hdr_wr_en = i_udp_wr_en.
  - In IP_TRIG/IP_WAIT: the same from the ip_* inputs.
  - Otherwise o_hdr_wr_en=0 and addr/data hold their last values.
  - Writes from the non-selected patcher are dropped.
- A ready pulse that coincides with the final timeout cycle counts as success; ready takes priority.
- A ready pulse from the non-active patcher, or any ready in IDLE, is ignored.
- The timer resets to 0 on entry to each WAIT state.

Test Plan:
1. Descriptor st=100, next=164; UDP patcher model writes idx4=0x00, idx5=0x4A then ready -> header writes addr 24=0x00, addr 25=0x4A one cycle later; o_ip_len=0x005E; IP model ready after 5 cycles -> single o_done pulse, o_busy falls.
2. Wrap: st=2040, next=8 (ADDR_WIDTH=11) -> difference 16, o_ip_len=46.
3. UDP model never asserts ready -> o_err pulse exactly TIMEOUT cycles after UDP_WAIT entry; o_ip_trig never asserted; o_pkt_ready returns.
4. IP model issues writes during UDP stage and UDP model during IP stage -> none appear on o_hdr_wr_en; selected writes all pass.
5. i_rst=1 during IP_WAIT -> next cycle all outputs at reset values, no o_done/o_err; new descriptor then completes normally.
6. i_pkt_valid held high continuously -> accepts spaced by full sequence plus 1 IDLE cycle; each o_udp_trig high exactly 2 cycles preceded by low.
